// File: rtl/mtm_alu_rx_deser.sv
// Serial packet receiver for the ALU datapath: deserialises 11-bit frames into
// operands B/A and a command byte, checks framing/structure/CRC4/opcode, and
// presents each packet or error report on a valid/ready port with overrun flag.
module mtm_alu_rx_deser #(
    parameter int unsigned DATA_W        = 32,
    parameter logic [7:0]  VALID_OP_MASK = 8'b0011_0011
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_a,
    output logic [2:0]        out_op,
    output logic [3:0]        out_err,
    output logic              overrun
);

    localparam int unsigned NB     = DATA_W / 8;
    localparam int unsigned NBYTES = 2 * NB;
    localparam int unsigned CNT_W  = $clog2(NBYTES + 1);

    typedef enum logic [2:0] {IDLE, TYPE, PAYLOAD, STOP, RESYNC} state_t;

    state_t            state, state_nxt;
    logic              is_cmd;
    logic [2:0]        bit_cnt;
    logic [7:0]        pay;
    logic [CNT_W-1:0]  byte_cnt;
    logic [3:0]        crc;
    logic [DATA_W-1:0] b_reg, a_reg;

    logic              data_full, b_full, op_bad, rpt, load;
    logic [3:0]        crc_fin, rpt_err;

    // One step of the x^4+x+1 LFSR, MSB-first, data bit folded into the feedback.
    function automatic logic [3:0] crc_step(input logic [3:0] c, input logic d);
        logic fb;
        fb = c[3] ^ d;
        return {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    endfunction

    // NOTE: every combinational output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!sin) state_nxt = TYPE;
            TYPE:    state_nxt = PAYLOAD;
            PAYLOAD: if (bit_cnt == 3'd7) state_nxt = STOP;
            STOP:    state_nxt = sin ? IDLE : RESYNC;
            RESYNC:  if (sin) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Report decision for the stop-bit cycle; the CRC tail {1'b1, op} comes from the CMD payload.
    always_comb begin
        data_full = (byte_cnt == CNT_W'(NBYTES));
        b_full    = (byte_cnt >= CNT_W'(NB));
        crc_fin   = crc_step(crc_step(crc_step(crc_step(crc, 1'b1), pay[6]), pay[5]), pay[4]);
        op_bad    = pay[7] | ~VALID_OP_MASK[pay[6:4]];
        rpt       = 1'b0;
        rpt_err   = 4'b0000;
        if (state == STOP) begin
            if (!sin) begin
                rpt     = 1'b1;
                rpt_err = 4'b1000;
            end else if (is_cmd) begin
                rpt     = 1'b1;
                rpt_err = data_full ? {2'b00, crc_fin != pay[3:0], op_bad} : 4'b0100;
            end else if (data_full) begin
                rpt     = 1'b1;
                rpt_err = 4'b0100;
            end
        end
        load = rpt && (!out_valid || out_ready);
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            is_cmd   <= 1'b0;
            bit_cnt  <= 3'd0;
            pay      <= 8'h00;
            byte_cnt <= '0;
            crc      <= 4'h0;
            // NOTE: the operand buffers are plain registers, so resetting them is cheap and keeps partial reports deterministic.
            b_reg    <= '0;
            a_reg    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                TYPE: begin
                    is_cmd  <= sin;
                    bit_cnt <= 3'd0;
                end
                PAYLOAD: begin
                    pay     <= {pay[6:0], sin};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (!is_cmd) crc <= crc_step(crc, sin);
                end
                STOP: begin
                    if (rpt) begin
                        byte_cnt <= '0;
                        crc      <= 4'h0;
                    end else begin
                        for (int k = 0; k < NB; k++) begin
                            if (byte_cnt == CNT_W'(k))      b_reg[(NB-1-k)*8 +: 8] <= pay;
                            if (byte_cnt == CNT_W'(NB + k)) a_reg[(NB-1-k)*8 +: 8] <= pay;
                        end
                        byte_cnt <= byte_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Holding buffer: a report loads when the slot is free or being drained this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_b     <= '0;
            out_a     <= '0;
            out_op    <= 3'd0;
            out_err   <= 4'd0;
            overrun   <= 1'b0;
        end else begin
            overrun <= rpt && out_valid && !out_ready;
            if (load) begin
                out_valid <= 1'b1;
                out_err   <= rpt_err;
                out_b     <= b_full ? b_reg : '0;
                out_a     <= data_full ? a_reg : '0;
                out_op    <= (is_cmd && sin) ? pay[6:4] : 3'd0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mtm_alu_rx_deser.md
Name: mtm_alu_rx_deser

Overview:
- Parametrised serial-packet receiver for the ALU datapath; successor to the fixed 32-bit deserializer stage that sits between `sin` and the ALU core.
- Receives byte frames on `sin` and assembles operands B and A of DATA_W bits each, plus a command byte.
- Checks framing, packet structure, CRC4 and opcode validity.
- Presents one packet at a time on a valid/ready interface, with a one-packet holding buffer and overrun reporting.

Parameters:
- DATA_W, 32, operand width in bits; multiple of 8, range 8..64; NB = DATA_W/8 bytes per operand.
- VALID_OP_MASK, 8'b0011_0011, bit k set means opcode k is legal (default: AND=000, OR=001, ADD=100, SUB=101).

Ports:
- clk  in  1  posedge clock
- rst_n  in  1  synchronous reset, active low
- sin  in  1  serial input, idle high, one bit per clk
- out_ready  in  1  downstream accepts the packet when high with out_valid
- out_valid  out  1  packet (or error report) available
- out_b  out  DATA_W  operand B
- out_a  out  DATA_W  operand A
- out_op  out  3  opcode
- out_err  out  4  {err_frame, err_data, err_crc, err_op}
- overrun  out  1  one-cycle pulse: completed packet dropped because the buffer was full

Behaviour:
- Reset: on clk edge with rst_n=0, all outputs 0, FSM to IDLE, byte counter 0, CRC state 0. Reset mid-frame or mid-packet discards everything.
- Frame format, 11 bits sampled one per clk:
  - start bit 0
  - type bit: 0 = DATA, 1 = CMD
  - 8 payload bits, MSB first
  - stop bit 1
- FSM states:
  - IDLE: sin=0 moves to TYPE.
  - TYPE → PAYLOAD (8 cycles) → STOP.
  - STOP → IDLE if sin=1; → RESYNC if sin=0.
  - RESYNC waits for sin=1, then goes to IDLE.
- Packet: 2*NB DATA bytes (B MSB-byte first, then A MSB-byte first), then one CMD byte {1'b0, op[2:0], crc[3:0]}.
- CRC:
  - Polynomial x^4+x+1, init 4'h0, no reflection, no final xor.
  - Computed MSB first over {B, A, 1'b1, op}, i.e. 2*DATA_W+4 bits.
  - Compared against crc[3:0] of the CMD byte.
  - CMD byte bit7 = 1 counts as err_op.
- Error rules, evaluated at a stop-bit cycle:
  - stop bit = 0: err_frame. Packet aborted; report issued.
  - CMD with fewer than 2*NB DATA bytes received: err_data.
  - DATA byte arriving when 2*NB DATA bytes are already held: err_data.
  - Otherwise, on CMD: err_crc if the CRC mismatches; err_op if the opcode is illegal or bit7=1. Both may be set together.
- Error reporting:
  - At most one of frame/data per report.
  - Any error report clears the byte counter.
  - out_a/out_b/out_op hold whatever was captured; fields not yet received read 0.
- Latency: out_valid rises on the clk edge after the final stop bit is sampled (one cycle after STOP).
- Handshake:
  - out_valid stays high and the payload stays stable until a cycle with out_ready=1.
  - out_valid falls on the next edge unless a new report completes in that same cycle; in that case the new report loads and out_valid stays high (back-to-back).
- Overrun:
  - A report completes while out_valid=1 and out_ready=0: the new report is dropped and overrun pulses for 1 cycle.
  - The held packet is unchanged.
  - Reception continues normally.
- Idle between frames and between packets is unlimited; back-to-back frames (start bit directly after stop bit) are legal.

Test Plan:
- Reset: hold rst_n=0 with sin toggling for 20 cycles → all outputs 0; first packet after release is received correctly.
- Nominal, DATA_W=32: B=32'h0000_0005, A=32'h0000_0003, op=100 with correct CRC, out_ready=1 → out_valid for 1 cycle one clk after the last stop bit; out_b=5, out_a=3, out_op=4, out_err=0.
- CRC and op: same packet with crc bit0 flipped → out_err=4'b0010. Then op=010 with correct CRC → out_err=4'b0001.
- Structure: CMD after 5 DATA bytes → out_err=4'b0100 and out_a=0. Then a 9th DATA byte → err_data at that frame's stop. Then a normal packet decodes cleanly.
- Framing: stop bit forced 0 mid-packet, sin held low 3 cycles → out_err=4'b1000; FSM resyncs; next packet decodes cleanly.
- Backpressure and width: DATA_W=8, out_ready=0, two valid packets back-to-back → first held stable, overrun=1 for exactly 1 cycle at the second's completion. Then out_ready=1 → first consumed, out_valid=0.
